// File: rtl/ratio_scale_pipe.sv
// ratio_scale_pipe: y = coef * x[sel] / sum(x), signed Q0.(DW-1), restoring divide then shift-add multiply
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_in_valid/o_in_ready operand handshake (ready only while idle)
//   i_x, i_sel            CH unsigned channels, numerator select (>=CH picks channel 0)
//   i_coef_sen/i_coef_sdi serial coefficient load, sign first then magnitude MSB first
//   o_out_valid/i_out_ready result handshake
//   o_y, o_div_zero       signed result, flag for zero channel sum
// Build option: RATIO_ROUND_EN enables round-half-up with saturation.
module ratio_scale_pipe #(
    parameter int DW = 12,
    parameter int CH = 3,
    parameter int FW = 14,
    parameter int CW = 13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [CH*DW-1:0]       i_x,
    input  logic [$clog2(CH)-1:0]  i_sel,
    input  logic                   i_coef_sen,
    input  logic                   i_coef_sdi,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [DW-1:0]          o_y,
    output logic                   o_div_zero
);
    localparam int SELW = $clog2(CH);
    localparam int SW   = DW + SELW;
    localparam int PW   = FW + CW + 1;
    localparam int NW   = $clog2(FW + CW);

    typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

    state_t          r_state, w_next;
    logic            r_in_ready;
    logic [CW:0]     r_coef;
    logic [SW:0]     r_rem;
    logic [SW-1:0]   r_sum;
    logic            r_sign;
    logic [CW-1:0]   r_mag;
    logic [PW-1:0]   r_q;
    logic [PW-1:0]   r_p;
    logic [NW-1:0]   r_cnt;
    logic [DW-1:0]   r_y;
    logic            r_dz;

    logic [SW-1:0]   w_sum;
    logic [DW-1:0]   w_num;
    logic            w_accept, w_zero, w_ge;
    logic [SW-1:0]   w_rd;
    logic [PW-1:0]   w_pf;
    logic [DW-1:0]   w_m, w_y;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < CH; i++)
            w_sum = w_sum + {{(SW-DW){1'b0}}, i_x[i*DW +: DW]};
    end

    always_comb begin
        w_num = i_x[DW-1:0];
        for (int i = 1; i < CH; i++)
            if (i_sel == SELW'(i)) w_num = i_x[i*DW +: DW];
    end

    assign w_accept = i_in_valid && r_in_ready;
    assign w_zero   = (w_sum == '0);

    // r_rem holds the remainder already doubled for the next step, so step 0 sees num unshifted
    assign w_ge = (r_rem >= {1'b0, r_sum});
    assign w_rd = w_ge ? SW'(r_rem - {1'b0, r_sum}) : r_rem[SW-1:0];

    // Final partial product including the add of the current cycle, so y can be registered on DONE entry
    assign w_pf = r_p + (r_mag[0] ? r_q : '0);

`ifdef RATIO_ROUND_EN
    localparam logic [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FW + CW - DW);
    logic [DW-1:0] w_pr;
    assign w_pr = DW'((w_pf + RND) >> (PW - DW));
    assign w_m  = w_pr[DW-1] ? {1'b0, {(DW-1){1'b1}}} : w_pr;
`else
    assign w_m = w_pf[PW-1 -: DW];
`endif

    assign w_y = r_sign ? -w_m : w_m;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_zero ? DONE : DIV;
            DIV:     if (r_cnt == NW'(FW)) w_next = MUL;
            MUL:     if (r_cnt == NW'(CW - 1)) w_next = DONE;
            DONE:    if (i_out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // in_ready is registered so it stays low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_coef <= '0;
        else if (i_coef_sen) r_coef <= {r_coef[CW-1:0], i_coef_sdi};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_sum  <= '0;
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_q    <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            r_y    <= '0;
            r_dz   <= 1'b0;
        end else if (w_accept) begin
            r_rem  <= {{(SW+1-DW){1'b0}}, w_num};
            r_sum  <= w_sum;
            r_sign <= r_coef[CW];
            r_mag  <= r_coef[CW-1:0];
            r_q    <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            if (w_zero) begin
                r_y  <= '0;
                r_dz <= 1'b1;
            end
        end else if (r_state == DIV) begin
            r_rem <= {w_rd, 1'b0};
            r_q   <= {r_q[PW-2:0], w_ge};
            r_cnt <= (w_next == MUL) ? '0 : r_cnt + NW'(1);
        end else if (r_state == MUL) begin
            r_p   <= w_pf;
            r_q   <= r_q << 1;
            r_mag <= r_mag >> 1;
            r_cnt <= r_cnt + NW'(1);
            if (w_next == DONE) begin
                r_y  <= w_y;
                r_dz <= 1'b0;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = (r_state == DONE);
    assign o_y         = r_y;
    assign o_div_zero  = r_dz;
endmodule

// File: doc/ratio_scale_pipe.md
# ratio_scale_pipe

Parametrised next-generation ratio scaler for the signal datapath. It accepts CH unsigned channels and a serially loaded signed coefficient, and computes y = coef × x[sel] / Σx as a signed DW-bit fixed-point result. A restoring divider and a shift-add multiplier share one FSM, and input and output use valid/ready handshakes. The block sits between the sample front end and the output register stage.

## Interface
Parameters:
- DW, 12, channel and output width
- CH, 3, number of input channels (≥2)
- FW, 14, quotient fraction bits
- CW, 13, coefficient magnitude bits (Q0.CW)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  operand valid
- in_ready  out  1  block idle, can accept
- x  in  CH*DW  channels, channel i at x[i*DW +: DW], unsigned
- sel  in  clog2(CH)  numerator channel; values ≥CH select channel 0
- coef_sen  in  1  coefficient shift enable
- coef_sdi  in  1  coefficient serial bit, sign first then magnitude MSB first
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- y  out  DW  signed two's-complement result, Q0.(DW-1)
- div_zero  out  1  Σx was zero for this result

## Operation
- Coefficient register coef_sr is CW+1 bits and resets to 0. Each cycle with coef_sen=1 it shifts left: coef_sr <= {coef_sr[CW-1:0], coef_sdi}. It is independent of FSM state.
- Accept means in_valid && in_ready. On accept the block latches num = x[sel], sum = Σx (width DW+clog2(CH)), sign = coef_sr[CW] and mag = coef_sr[CW-1:0]. Later coefficient shifts do not affect the operation in flight.
- FSM states:
  - IDLE -> DIV on accept with sum≠0.
  - IDLE -> DONE on accept with sum=0. In this case y=0 and div_zero=1.
  - DIV -> MUL after FW+1 cycles.
  - MUL -> DONE after CW cycles.
  - DONE -> IDLE when out_ready=1.
- DIV computes the quotient q, FW+1 bits:
  - Remainder starts at num.
  - Step 0: q[FW] = (rem ≥ sum), and rem is reduced by sum if set.
  - Steps 1..FW: rem <= 2·rem, then compare/subtract as in step 0, giving bits q[FW-1:0].
  - Result: q = floor(num·2^FW / sum) ≤ 2^FW.
- MUL computes p = q·mag by shift-add, one mag bit per cycle, LSB first. p has FW+CW+1 bits.
- Output magnitude m = p >> (FW+CW-DW+1), truncated.
  - Because p < 2^(FW+CW), m ≤ 2^(DW-1)-1 and no overflow occurs.
  - y = sign ? -m : m. A negative zero is output as 0.
- y and div_zero are registered on entry to DONE. They hold stable while out_valid=1 && out_ready=0.
- in_ready=1 only in IDLE. in_valid is ignored in every other state.

## Timing
- Reset values:
  - in_ready=0; it goes to 1 on the first clk edge after rst_n deasserts.
  - out_valid=0, y=0, div_zero=0, coef_sr=0, state=IDLE.
- Latency from the accept edge to out_valid=1:
  - FW+CW+2 edges when sum≠0 (29 at defaults).
  - 1 edge when sum=0.
- out_valid is asserted in DONE. On the edge where out_valid && out_ready, out_valid falls and in_ready rises on that same edge, with no bubble beyond the one idle cycle.
- rst_n asserted in any state aborts the operation immediately. No partial result is emitted.
- Throughput: one result per FW+CW+3 cycles maximum.

## Configuration
- RATIO_ROUND_EN defined:
  - Adds 2^(FW+CW-DW) to p before the shift (round half up).
  - If the rounded m reaches 2^(DW-1), it saturates to 2^(DW-1)-1.
  - Latency is unchanged.
- RATIO_ROUND_EN undefined: pure truncation as in Operation.

## Test plan
- x=(1000,1000,2000), sel=0, coef +4096 -> q=4096, y=256 after 29 cycles, div_zero=0.
- Same operands, coef sign=1 -> y=12'hF00 (-256).
- x=(0,0,0), any coef -> out_valid one cycle after accept, y=0, div_zero=1.
- x=(1,0,2), sel=0, coef +8191 -> q=5461, y=682 without RATIO_ROUND_EN, y=683 with it.
- Result pending, out_ready held low 10 cycles, in_valid=1 and coef_sen toggling throughout:
  - y stays stable and in_ready stays 0.
  - Release out_ready: the next cycle has in_ready=1 and the new accept uses the updated coef_sr.
- rst_n pulsed low mid-DIV:
  - out_valid=0 and state returns to IDLE.
  - in_ready=1 one edge after release.
  - A subsequent operation gives the correct result.
